core_wb_arbiter: RTL and testbench
==================================

Name: core_wb_arbiter

Overview:
- Shares the single register-file write port between three writeback requesters: load/store unit (LSU), ALU, and debug port (DBG).
- Fixed-priority arbitration with a starvation override. A registered output stage drives the register file's AWVALID/AWADDR/WDATA.
- Sits between the execute/memory stages and the register file. Exports a pending-write mask so decode can stall on a read-after-write hazard.

Parameters:
- STARVE_LIMIT, 4: consecutive waiting cycles after which a requester is forced to win; legal 1..7.
- CNT_W, 3: width of each per-requester wait counter; must satisfy 2^CNT_W-1 >= STARVE_LIMIT.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous reset, active-high
- HOLD  in  1  when 1: no grants, wait counters frozen
- LSU_VALID  in  1  LSU write request
- LSU_ADDR  in  5  LSU destination register
- LSU_DATA  in  32  LSU write data
- LSU_READY  out  1  LSU grant (combinational)
- ALU_VALID / ALU_ADDR / ALU_DATA / ALU_READY  same as LSU set
- DBG_VALID / DBG_ADDR / DBG_DATA / DBG_READY  same as LSU set
- AWVALID  out  1  register-file write enable (registered)
- AWADDR  out  5  register-file write address (registered)
- WDATA  out  32  register-file write data (registered)
- PENDING  out  32  one-hot of AWADDR when AWVALID=1, else 0

Behaviour:
- Reset: asynchronous on RST=1. AWVALID=0, AWADDR=0, WDATA=0, PENDING=0, all wait counters=0. All READY=0 while RST=1.
- Handshake: a transfer occurs when X_VALID && X_READY in the same cycle.
  - Once asserted, X_VALID, X_ADDR and X_DATA hold stable until the transfer.
  - The arbiter never retracts READY within a cycle.
  - At most one READY is high per cycle.
- Grant is combinational from current VALIDs, HOLD and the counters; there is no grant state between cycles. HOLD=1 forces all READY=0.
- Priority with no starvation: LSU > ALU > DBG.
- Starvation override: if any requester has VALID=1 and wait counter >= STARVE_LIMIT, the highest-priority such starved requester wins, regardless of normal priority.
- Wait counters, per requester:
  - Clear to 0 on that requester's transfer, or when its VALID=0.
  - Increment (saturating at 2^CNT_W-1) when VALID=1 && READY=0 && HOLD=0.
  - Hold when HOLD=1.
- Output stage, one cycle latency: transfer in cycle N gives AWVALID=1 with the winner's ADDR/DATA in cycle N+1.
  - No transfer in cycle N gives AWVALID=0 in N+1.
  - AWADDR/WDATA keep their last values when AWVALID=0.
- x0 writes: a request with ADDR=0 completes its handshake normally, but AWVALID stays 0 in N+1. PENDING does not mark it.
- No backpressure from the register file; the output stage drains every cycle, so throughput is one write per cycle.
- Same address from two requesters in consecutive cycles: writes commit in grant order; the later grant wins.
- RST mid-operation: any in-flight output-stage write is discarded (AWVALID→0 immediately) and counters clear. Requesters keep VALID asserted and are re-arbitrated after RST deasserts.
- RST deassertion is synchronous to CLK; the first grant is possible in the first cycle with RST=0.

Decomposition:
- Shared package constants: REQ_LSU=0, REQ_ALU=1, REQ_DBG=2, NUM_REQ=3, REG_ADDR_W=5, XLEN=32.
- One sub-module, core_wb_prio_sel: pure combinational selector taking VALID[2:0], starved[2:0] and HOLD, producing one-hot grant[2:0].
- Counters, output register and PENDING decode live in core_wb_arbiter.

Test Plan:
- Reset: RST=1 asynchronously mid-cycle with AWVALID=1 → AWVALID=0, PENDING=0 before next edge; after release with LSU_VALID=1, ADDR=5, DATA=0xDEADBEEF → next cycle AWVALID=1, AWADDR=5, WDATA=0xDEADBEEF, PENDING=0x00000020.
- Priority: LSU (ADDR=1), ALU (ADDR=2), DBG (ADDR=3) all VALID in same cycle → LSU_READY only; LSU, ALU and DBG commit on consecutive cycles (AWADDR 1,2,3).
- Starvation: LSU and ALU continuously valid (new ALU/LSU transfers each cycle) with DBG_VALID=1, STARVE_LIMIT=4 → DBG_READY=1 exactly in the 5th cycle of waiting; its counter returns to 0.
- x0 drop: ALU_VALID=1, ADDR=0, DATA=0x1234 → ALU_READY=1, next cycle AWVALID=0, PENDING=0.
- HOLD: HOLD=1 for 3 cycles with DBG_VALID=1 → all READY=0, DBG counter unchanged; HOLD=0 → DBG granted (no other requesters), AWADDR=DBG_ADDR next cycle.
- Back-to-back same address: LSU writes x7=0xA, then ALU writes x7=0xB the next cycle → AWADDR=7 with WDATA=0xA then 0xB; PENDING=0x80 for both cycles.

Source files
------------

// File: rtl/core_wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter.
// Requester indices, register-file widths, lowest-set-bit pick.
package core_wb_arbiter_pkg;

  localparam int REQ_LSU    = 0;
  localparam int REQ_ALU    = 1;
  localparam int REQ_DBG    = 2;
  localparam int NUM_REQ    = 3;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Lowest set bit wins: index 0 is highest priority.
  function automatic req_vec_t first_one(
    input req_vec_t v
  );
    first_one = v & (~v + req_vec_t'(1));
  endfunction

endpackage

// File: rtl/core_wb_prio_sel.sv
// Combinational fixed-priority selector with starvation override.
// Ports: i_valid, i_starved, i_hold in; one-hot o_grant out.
module core_wb_prio_sel
  import core_wb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [NUM_REQ-1:0] i_starved,
  input  logic               i_hold,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [NUM_REQ-1:0] w_starved;

  always_comb begin
    o_grant   = '0;
    w_starved = i_valid & i_starved;
    if (!i_hold) begin
      // A starved requester preempts normal priority.
      if (|w_starved)
        o_grant = first_one(w_starved);
      else
        o_grant = first_one(i_valid);
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Register-file writeback arbiter for LSU, ALU and debug requesters.
// Ports: CLK/RST/HOLD, X_VALID/ADDR/DATA in, X_READY out, AW*/WDATA/PENDING out.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  HOLD,
  input  logic                  LSU_VALID,
  input  logic [REG_ADDR_W-1:0] LSU_ADDR,
  input  logic [XLEN-1:0]       LSU_DATA,
  output logic                  LSU_READY,
  input  logic                  ALU_VALID,
  input  logic [REG_ADDR_W-1:0] ALU_ADDR,
  input  logic [XLEN-1:0]       ALU_DATA,
  output logic                  ALU_READY,
  input  logic                  DBG_VALID,
  input  logic [REG_ADDR_W-1:0] DBG_ADDR,
  input  logic [XLEN-1:0]       DBG_DATA,
  output logic                  DBG_READY,
  output logic                  AWVALID,
  output logic [REG_ADDR_W-1:0] AWADDR,
  output logic [XLEN-1:0]       WDATA,
  output logic [XLEN-1:0]       PENDING
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0]    w_valid;
  logic [NUM_REQ-1:0]    w_starved;
  logic [NUM_REQ-1:0]    w_grant;
  logic [REG_ADDR_W-1:0] w_addr [NUM_REQ];
  logic [XLEN-1:0]       w_data [NUM_REQ];
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_xfer;
  logic                  w_write;

  logic [CNT_W-1:0]      r_cnt [NUM_REQ];
  logic                  r_awvalid;
  logic [REG_ADDR_W-1:0] r_awaddr;
  logic [XLEN-1:0]       r_wdata;

  assign w_valid[REQ_LSU] = LSU_VALID;
  assign w_valid[REQ_ALU] = ALU_VALID;
  assign w_valid[REQ_DBG] = DBG_VALID;
  assign w_addr[REQ_LSU]  = LSU_ADDR;
  assign w_addr[REQ_ALU]  = ALU_ADDR;
  assign w_addr[REQ_DBG]  = DBG_ADDR;
  assign w_data[REQ_LSU]  = LSU_DATA;
  assign w_data[REQ_ALU]  = ALU_DATA;
  assign w_data[REQ_DBG]  = DBG_DATA;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_starved[i] = (r_cnt[i] >= LIMIT);
  end

  // Reset also suppresses grants so no READY leaks during RST.
  core_wb_prio_sel u_sel (
    .i_valid   (w_valid),
    .i_starved (w_starved),
    .i_hold    (HOLD | RST),
    .o_grant   (w_grant)
  );

  assign LSU_READY = w_grant[REQ_LSU];
  assign ALU_READY = w_grant[REQ_ALU];
  assign DBG_READY = w_grant[REQ_DBG];

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = w_addr[i];
        w_sel_data = w_data[i];
      end
    end
  end

  assign w_xfer  = |w_grant;
  // x0 handshakes complete but never reach the register file.
  assign w_write = w_xfer && (w_sel_addr != '0);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)
        r_cnt[g] <= '0;
      else if (!w_valid[g])
        r_cnt[g] <= '0;
      else if (HOLD)
        r_cnt[g] <= r_cnt[g];
      else if (w_grant[g])
        r_cnt[g] <= '0;
      else if (r_cnt[g] != CNT_MAX)
        r_cnt[g] <= r_cnt[g] + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      r_awvalid <= w_write;
      if (w_write) begin
        r_awaddr <= w_sel_addr;
        r_wdata  <= w_sel_data;
      end
    end
  end

  assign AWVALID = r_awvalid;
  assign AWADDR  = r_awaddr;
  assign WDATA   = r_wdata;

  always_comb begin
    PENDING = '0;
    if (r_awvalid)
      PENDING[r_awaddr] = 1'b1;
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed testbench for core_wb_arbiter.
// Drives requests after each rising edge and checks outputs 1ns later.
module tb_core_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HOLD = 1'b0;
  logic        LSU_VALID = 1'b0;
  logic [4:0]  LSU_ADDR = '0;
  logic [31:0] LSU_DATA = '0;
  logic        LSU_READY;
  logic        ALU_VALID = 1'b0;
  logic [4:0]  ALU_ADDR = '0;
  logic [31:0] ALU_DATA = '0;
  logic        ALU_READY;
  logic        DBG_VALID = 1'b0;
  logic [4:0]  DBG_ADDR = '0;
  logic [31:0] DBG_DATA = '0;
  logic        DBG_READY;
  logic        AWVALID;
  logic [4:0]  AWADDR;
  logic [31:0] WDATA;
  logic [31:0] PENDING;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  core_wb_arbiter #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .HOLD      (HOLD),
    .LSU_VALID (LSU_VALID),
    .LSU_ADDR  (LSU_ADDR),
    .LSU_DATA  (LSU_DATA),
    .LSU_READY (LSU_READY),
    .ALU_VALID (ALU_VALID),
    .ALU_ADDR  (ALU_ADDR),
    .ALU_DATA  (ALU_DATA),
    .ALU_READY (ALU_READY),
    .DBG_VALID (DBG_VALID),
    .DBG_ADDR  (DBG_ADDR),
    .DBG_DATA  (DBG_DATA),
    .DBG_READY (DBG_READY),
    .AWVALID   (AWVALID),
    .AWADDR    (AWADDR),
    .WDATA     (WDATA),
    .PENDING   (PENDING)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // READY bits packed as {DBG, ALU, LSU}.
  function automatic logic [31:0] rdy();
    return {29'd0, DBG_READY, ALU_READY, LSU_READY};
  endfunction

  task automatic chk_out(input string tag, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_awvalid"}, {31'd0, AWVALID}, {31'd0, v});
    chk({tag, "_awaddr"}, {27'd0, AWADDR}, {27'd0, a});
    chk({tag, "_wdata"}, WDATA, d);
    chk({tag, "_pending"}, PENDING, v ? (32'd1 << a) : 32'd0);
  endtask

  initial begin
    // Reset state, with LSU requesting during reset.
    LSU_VALID = 1'b1;
    LSU_ADDR  = 5'd5;
    LSU_DATA  = 32'hDEADBEEF;
    #2;
    chk_out("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_ready", rdy(), 32'd0);

    // First grant in first cycle with RST=0.
    tick;
    RST = 1'b0;
    #1;
    chk("rel_ready", rdy(), 32'd1);
    tick;
    chk_out("rel_commit", 1'b1, 5'd5, 32'hDEADBEEF);
    LSU_VALID = 1'b0;

    // Asynchronous reset mid-cycle discards the output write.
    #2;
    RST = 1'b1;
    #1;
    chk("arst_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("arst_pending", PENDING, 32'd0);
    tick;
    RST = 1'b0;
    #1;
    chk("arst_idle_ready", rdy(), 32'd0);

    // Priority: all three valid.
    LSU_VALID = 1'b1; LSU_ADDR = 5'd1; LSU_DATA = 32'h11;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd2; ALU_DATA = 32'h22;
    DBG_VALID = 1'b1; DBG_ADDR = 5'd3; DBG_DATA = 32'h33;
    #1;
    chk("prio_c0", rdy(), 32'b001);
    tick;
    chk_out("prio_w1", 1'b1, 5'd1, 32'h11);
    LSU_VALID = 1'b0;
    #1;
    chk("prio_c1", rdy(), 32'b010);
    tick;
    chk_out("prio_w2", 1'b1, 5'd2, 32'h22);
    ALU_VALID = 1'b0;
    #1;
    chk("prio_c2", rdy(), 32'b100);
    tick;
    chk_out("prio_w3", 1'b1, 5'd3, 32'h33);
    DBG_VALID = 1'b0;
    tick;
    chk("prio_idle", {31'd0, AWVALID}, 32'd0);

    // Starvation: DBG waits 4 cycles, wins the 5th.
    DBG_VALID = 1'b1; DBG_ADDR = 5'd12; DBG_DATA = 32'hD0;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd11;
    LSU_ADDR  = 5'd10;
    for (int i = 0; i < 5; i++) begin
      LSU_VALID = (i % 2 == 0);
      LSU_DATA  = 32'h100 + i;
      ALU_DATA  = 32'h200 + (i / 2);
      #1;
      if (i == 4)
        chk("starve_win", rdy(), 32'b100);
      else if (i % 2 == 0)
        chk("starve_lsu", rdy(), 32'b001);
      else
        chk("starve_alu", rdy(), 32'b010);
      tick;
      if (i == 4)
        chk_out("starve_wd", 1'b1, 5'd12, 32'hD0);
      else if (i % 2 == 0)
        chk_out("starve_wl", 1'b1, 5'd10, 32'h100 + i);
      else
        chk_out("starve_wa", 1'b1, 5'd11, 32'h200 + (i / 2));
    end
    // DBG counter restarted: a fresh DBG request loses to LSU.
    DBG_ADDR = 5'd13; DBG_DATA = 32'hD1;
    #1;
    chk("starve_clr", rdy(), 32'b001);
    tick;
    chk_out("starve_wl5", 1'b1, 5'd10, 32'h104);
    LSU_VALID = 1'b0;
    #1;
    chk("drain_alu", rdy(), 32'b010);
    tick;
    chk_out("drain_wa", 1'b1, 5'd11, 32'h202);
    ALU_VALID = 1'b0;
    #1;
    chk("drain_dbg", rdy(), 32'b100);
    tick;
    chk_out("drain_wd", 1'b1, 5'd13, 32'hD1);
    DBG_VALID = 1'b0;

    // x0 write: handshake completes, nothing committed.
    ALU_VALID = 1'b1; ALU_ADDR = 5'd0; ALU_DATA = 32'h1234;
    #1;
    chk("x0_ready", rdy(), 32'b010);
    tick;
    chk_out("x0_drop", 1'b0, 5'd13, 32'hD1);
    ALU_VALID = 1'b0;

    // HOLD blocks all grants.
    HOLD = 1'b1;
    DBG_VALID = 1'b1; DBG_ADDR = 5'd20; DBG_DATA = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", rdy(), 32'd0);
      tick;
      chk("hold_awvalid", {31'd0, AWVALID}, 32'd0);
    end
    HOLD = 1'b0;
    #1;
    chk("hold_rel", rdy(), 32'b100);
    tick;
    chk_out("hold_w", 1'b1, 5'd20, 32'hCAFE);
    DBG_VALID = 1'b0;

    // Back-to-back writes to the same register.
    LSU_VALID = 1'b1; LSU_ADDR = 5'd7; LSU_DATA = 32'hA;
    #1;
    chk("b2b_lsu", rdy(), 32'b001);
    tick;
    chk_out("b2b_wa", 1'b1, 5'd7, 32'hA);
    LSU_VALID = 1'b0;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd7; ALU_DATA = 32'hB;
    #1;
    chk("b2b_alu", rdy(), 32'b010);
    tick;
    chk_out("b2b_wb", 1'b1, 5'd7, 32'hB);
    ALU_VALID = 1'b0;
    tick;
    chk_out("b2b_idle", 1'b0, 5'd7, 32'hB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
